// File: rtl/btn_cnt_pkg.sv
// Shared helpers, derived widths and the repeat-timer state type for the
// debounced multi-channel button counter.
package btn_cnt_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Prescaler never collapses to zero bits, even with one clock per sample.
    function automatic int presc_w(input int clks_per_smpl);
        return (clks_per_smpl > 1) ? clog2(clks_per_smpl) : 1;
    endfunction

    function automatic int tmr_w(input int hold_clks, input int rpt_clks);
        return clog2(max2(hold_clks, rpt_clks) + 1);
    endfunction

    localparam int DEF_CLKS_PER_SMPL = 16;
    localparam int DEF_HOLD_CLKS     = 1000;
    localparam int DEF_RPT_CLKS      = 200;

    localparam int PRESC_W = presc_w(DEF_CLKS_PER_SMPL);
    localparam int TMR_W   = tmr_w(DEF_HOLD_CLKS, DEF_RPT_CLKS);

    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,
        RPT_HOLD = 2'd1,
        RPT_RUN  = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/btn_cnt_multi_btn_evt.sv
// One button path: 2-flop synchroniser, sample-window debouncer, press-edge
// detector and hold-to-repeat timer. evt is a registered one-clock pulse.
module btn_evt
    import btn_cnt_pkg::*;
#(
    parameter int SMPL_CNT  = 4,
    parameter int RPT_EN    = 1,
    parameter int HOLD_CLKS = 1000,
    parameter int RPT_CLKS  = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic db,
    output logic evt
);

    localparam int TW = tmr_w(HOLD_CLKS, RPT_CLKS);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CLKS - 1);
    localparam logic [TW-1:0] RPT_LOAD  = TW'(RPT_CLKS - 1);

    logic                sync1_q;
    logic                sync2_q;
    logic [SMPL_CNT-1:0] hist_q;
    logic [SMPL_CNT-1:0] hist_d;
    logic                db_q;
    logic                db_d;
    logic                db_prev_q;
    logic                evt_q;
    logic                evt_d;
    logic                press;
    rpt_state_e          state_q;
    rpt_state_e          state_d;
    logic [TW-1:0]       tmr_q;
    logic [TW-1:0]       tmr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hist_q    <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            evt_q     <= 1'b0;
            state_q   <= RPT_IDLE;
            tmr_q     <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            hist_q    <= hist_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            evt_q     <= evt_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
        end
    end

    // The level only moves when the whole sample window agrees.
    always_comb begin
        hist_d = hist_q;
        db_d   = db_q;
        if (tick) begin
            hist_d = {hist_q[SMPL_CNT-2:0], sync2_q};
            if (&hist_d) begin
                db_d = 1'b1;
            end else if (~|hist_d) begin
                db_d = 1'b0;
            end
        end
    end

    // Repeat decisions look at db_d so a release on this edge suppresses
    // any repeat that would otherwise land in the release cycle.
    always_comb begin
        press   = db_q & ~db_prev_q;
        evt_d   = press;
        state_d = state_q;
        tmr_d   = tmr_q;
        if (RPT_EN != 0) begin
            if (!db_d) begin
                state_d = RPT_IDLE;
                tmr_d   = '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        if (press) begin
                            state_d = RPT_HOLD;
                            tmr_d   = HOLD_LOAD;
                        end
                    end
                    RPT_HOLD, RPT_RUN: begin
                        if (tmr_q == '0) begin
                            evt_d   = 1'b1;
                            state_d = RPT_RUN;
                            tmr_d   = RPT_LOAD;
                        end else begin
                            tmr_d = tmr_q - TW'(1);
                        end
                    end
                    default: begin
                        state_d = RPT_IDLE;
                        tmr_d   = '0;
                    end
                endcase
            end
        end
    end

    assign db  = db_q;
    assign evt = evt_q;

endmodule

// File: rtl/btn_cnt_multi.sv
// Multi-channel debounced up/down button counter: shared sample prescaler,
// one btn_evt per button, and a wrap or saturate counter per channel.
module btn_cnt_multi
    import btn_cnt_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int CNT_W         = 4,
    parameter int CLKS_PER_SMPL = 16,
    parameter int SMPL_CNT      = 4,
    parameter int SAT           = 0,
    parameter int RPT_EN        = 1,
    parameter int HOLD_CLKS     = 1000,
    parameter int RPT_CLKS      = 200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         btn_up,
    input  logic [N_CH-1:0]         btn_dn,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH-1:0]         db_up,
    output logic [N_CH-1:0]         db_dn,
    output logic [N_CH-1:0]         evt_up,
    output logic [N_CH-1:0]         evt_dn,
    output logic [N_CH*CNT_W-1:0]   cnt
);

    localparam int PW = presc_w(CLKS_PER_SMPL);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLKS_PER_SMPL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             tick;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_evt #(
            .SMPL_CNT  (SMPL_CNT),
            .RPT_EN    (RPT_EN),
            .HOLD_CLKS (HOLD_CLKS),
            .RPT_CLKS  (RPT_CLKS)
        ) u_up (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (btn_up[g]),
            .db    (db_up[g]),
            .evt   (evt_up[g])
        );

        btn_evt #(
            .SMPL_CNT  (SMPL_CNT),
            .RPT_EN    (RPT_EN),
            .HOLD_CLKS (HOLD_CLKS),
            .RPT_CLKS  (RPT_CLKS)
        ) u_dn (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (btn_dn[g]),
            .db    (db_dn[g]),
            .evt   (evt_dn[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Clear wins; opposing events cancel; saturation only blocks the step.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr[i]) begin
                cnt_d[i] = '0;
            end else if (evt_up[i] && evt_dn[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (evt_up[i]) begin
                if (!((SAT != 0) && (cnt_q[i] == CNT_MAX))) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (evt_dn[i]) begin
                if (!((SAT != 0) && (cnt_q[i] == '0))) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: doc/btn_cnt_multi.md
Name: btn_cnt_multi

Overview:
- Multi-channel debounced button counter. Each channel has an up button and a down button, and keeps its own CNT_W-bit counter.
- Each button passes through a synchroniser, a sample-window debouncer, a press-edge detector and an optional hold-to-repeat generator.
- Wrap or saturate arithmetic is selectable at build time.
- Sits between raw board pushbuttons and front-panel logic (LED/7-seg drivers, setting registers).

Parameters:
- N_CH, 2: number of channels; each channel has one up and one down button.
- CNT_W, 4: width of each channel counter (>=1).
- CLKS_PER_SMPL, 16: clocks between debounce samples; one prescaler shared by all buttons.
- SMPL_CNT, 4: number of consecutive identical samples needed to change the debounced level (>=2).
- SAT, 0: 0 = wrap modulo 2^CNT_W; 1 = saturate at 0 and 2^CNT_W-1.
- RPT_EN, 1: 1 = auto-repeat while a button is held; 0 = one event per press.
- HOLD_CLKS, 1000: clocks from the press event to the first repeat event.
- RPT_CLKS, 200: clocks between subsequent repeat events (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- btn_up  in  N_CH  raw asynchronous up buttons, active-high
- btn_dn  in  N_CH  raw asynchronous down buttons, active-high
- clr  in  N_CH  synchronous per-channel counter clear, active-high
- db_up  out  N_CH  debounced up levels
- db_dn  out  N_CH  debounced down levels
- evt_up  out  N_CH  one-cycle up event pulses (press or repeat)
- evt_dn  out  N_CH  one-cycle down event pulses (press or repeat)
- cnt  out  N_CH*CNT_W  counters, packed; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset: all flops clear asynchronously. cnt=0, db_*=0, evt_*=0, prescaler=0, sample history=0, repeat timers idle.
- Synchroniser: 2-flop per raw input. The debouncer sees only the synchronised value.
- Sample tick: the prescaler counts 0..CLKS_PER_SMPL-1; tick is high for one clk when it wraps to 0.
- Debounce: on each tick, shift the synchronised sample into a SMPL_CNT-deep history.
  - All ones: db goes to 1.
  - All zeros: db goes to 0.
  - Otherwise: db holds.
  - db changes only on tick edges.
- Press event: evt is high in the cycle after db rises (db & ~db_prev, db_prev registered). Exactly one clk wide. No event on release.
- Repeat (RPT_EN=1): a per-button timer starts at the press event.
  - While db stays 1, repeat events fire at press+HOLD_CLKS, then every RPT_CLKS.
  - db falling returns the timer to idle immediately. No event in the release cycle.
  - Timer width is $clog2(max(HOLD_CLKS, RPT_CLKS)+1).
- Counter update: cnt changes on the clk edge that ends the evt cycle. Latency db rise to cnt change is 2 clks.
- Per-channel update priority:
  - clr: cnt <= 0.
  - evt_up & evt_dn together: no change.
  - evt_up: +1.
  - evt_dn: -1.
- Wrap, SAT=0: 2^CNT_W-1 + 1 gives 0; 0 - 1 gives 2^CNT_W-1.
- Saturate, SAT=1: values clamp at the ends. Events still pulse at the limits.
- clr does not affect debounce or repeat state.
- A button held through reset is treated as a new press: one event once SMPL_CNT post-reset samples agree.
- Channels are fully independent apart from the shared prescaler.

Decomposition:
- Package btn_cnt_pkg holds:
  - function clog2;
  - localparam-style constants PRESC_W and TMR_W derived from the parameters;
  - enum typedef for repeat state: RPT_IDLE, RPT_HOLD, RPT_RUN.
- Sub-module btn_evt, instantiated 2*N_CH times. It contains the synchroniser, history register, db, edge detect and repeat FSM.
  - Inputs: clk, rst_n, tick, raw.
  - Outputs: db, evt.
- Top level holds the prescaler, the counters and the packing.

Test Plan:
- Clean press (defaults): btn_up[0] high for 200 clks, then low -> exactly one evt_up[0] pulse; cnt[0] 0->1; db_up[0] rises within 2+16*4+16 clks.
- Bounce: btn_up[0] toggles every 5 clks for 60 clks, then stays low -> db_up[0] stays 0; no evt; cnt stays 0.
- Wrap vs saturate: 16 up presses from 0.
  - SAT=0: cnt=0.
  - SAT=1: cnt=15. A further down press gives 14.
  - Reset, then one down press with SAT=1: cnt stays 0.
- Auto-repeat: hold btn_up[1] for 1500 clks past the press event -> events at +0, +1000, +1200, +1400; cnt[1]=4. With RPT_EN=0 -> cnt[1]=1.
- Simultaneous events / clr: btn_up[0] and btn_dn[0] driven identically with cnt=5 -> cnt stays 5. Pulse clr[0] in the same cycle as evt_up[0] -> cnt=0.
- Reset mid-hold: assert rst_n low during the repeat phase -> all outputs 0 immediately. Release with the button still held -> one new press event after debounce; cnt=1.
